// File: rtl/snes_frame_scheduler.sv
// SNES TAS frame scheduler: pops one frame per console latch, shifts it out on d0.
// Optional lag watchdog enabled by defining SNES_LAG_WATCHDOG_EN.
module snes_frame_scheduler #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] IDLE_WORD   = 32'hFFFFFFFF,
    parameter logic             FILL_BIT    = 1'b1,
    parameter int               SYNC_STAGES = 2,
    parameter int               WDOG_CYCLES = 1000000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             snes_lat,
    input  logic             snes_clk,
    input  logic [WIDTH-1:0] frame_data,
    input  logic             frame_valid,
    output logic             frame_pop,
    output logic             d0,
    output logic             busy,
    output logic [15:0]      frame_count,
    output logic             underrun,
    output logic             lag_timeout,
    input  logic             clr_status
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] lat_sync_q, lat_sync_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic                   lat_prev_q, clk_prev_q;
    logic                   lat_s, clk_s, lat_rise, clk_rise;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              pop_q, pop_d;
    logic              busy_q, busy_d;
    logic [15:0]       count_q, count_d;
    logic              underrun_q, underrun_d;

    assign lat_s    = lat_sync_q[SYNC_STAGES-1];
    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign lat_rise = lat_s & ~lat_prev_q;
    assign clk_rise = clk_s & ~clk_prev_q;

    // Shift the async console pins through the synchronizer chains
    always_comb begin
        lat_sync_d = {lat_sync_q[SYNC_STAGES-2:0], snes_lat};
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], snes_clk};
    end

    // Next-state logic: latch always reloads and wins over a same-cycle clock
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        pop_d      = 1'b0;
        count_d    = count_q;
        underrun_d = underrun_q & ~clr_status;
        if (lat_rise) begin
            state_d   = LOADED;
            bit_cnt_d = '0;
            if (frame_valid) begin
                sr_d    = frame_data;
                pop_d   = 1'b1;
                count_d = count_q + 16'd1;
            end else begin
                sr_d       = IDLE_WORD;
                underrun_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                LOADED: if (!lat_s) state_d = SHIFT;
                SHIFT: begin
                    if (clk_rise) begin
                        sr_d      = {sr_q[WIDTH-2:0], FILL_BIT};
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        if (bit_cnt_q == LAST) state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d == LOADED) || (state_d == SHIFT);
    end

    // Register synchronizers, FSM and status outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lat_sync_q <= '0;
            clk_sync_q <= '1;
            lat_prev_q <= 1'b0;
            clk_prev_q <= 1'b1;
            state_q    <= IDLE;
            sr_q       <= IDLE_WORD;
            bit_cnt_q  <= '0;
            pop_q      <= 1'b0;
            busy_q     <= 1'b0;
            count_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            lat_sync_q <= lat_sync_d;
            clk_sync_q <= clk_sync_d;
            lat_prev_q <= lat_s;
            clk_prev_q <= clk_s;
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            pop_q      <= pop_d;
            busy_q     <= busy_d;
            count_q    <= count_d;
            underrun_q <= underrun_d;
        end
    end

    assign d0          = sr_q[WIDTH-1];
    assign frame_pop   = pop_q;
    assign busy        = busy_q;
    assign frame_count = count_q;
    assign underrun    = underrun_q;

`ifdef SNES_LAG_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WMAX = WW'(WDOG_CYCLES);

    logic [WW-1:0] wdog_q, wdog_d;
    logic          lag_q, lag_d;

    // Count cycles since the last latch, saturating at the limit
    always_comb begin
        wdog_d = wdog_q;
        lag_d  = lag_q & ~clr_status;
        if (lat_rise)           wdog_d = '0;
        else if (wdog_q != WMAX) wdog_d = wdog_q + WW'(1);
        if (wdog_q == WMAX)     lag_d  = 1'b1;
    end

    // Register watchdog counter and sticky flag
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wdog_q <= '0;
            lag_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            lag_q  <= lag_d;
        end
    end

    assign lag_timeout = lag_q;
`else
    assign lag_timeout = 1'b0;
`endif

endmodule
